// File: rtl/truth_table_sweeper_if.sv
// Bundle between the test controller / gate under test and the truth-table sweeper.
// The slave modport is the sweeper's view; the master modport is the controller and gate side.
interface truth_table_sweeper_if #(
  parameter int unsigned N_INPUTS = 4
);
  localparam int unsigned TblW = 1 << N_INPUTS;

  logic                start;
  logic                abort;
  logic [TblW-1:0]     expected;
  logic                dut_y;
  logic [N_INPUTS-1:0] dut_in;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic [TblW-1:0]     table_out;
  logic [N_INPUTS:0]   mismatch_count;
  logic                pass;

  modport master (
    output start, abort, expected, dut_y,
    input  dut_in, busy, done, result_valid, table_out, mismatch_count, pass
  );

  modport slave (
    input  start, abort, expected, dut_y,
    output dut_in, busy, done, result_valid, table_out, mismatch_count, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks an N-input gate through every input vector in ascending order, captures its truth
// table and scores it against a table latched at start.
module truth_table_sweeper #(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int unsigned TblW = 1 << N_INPUTS;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StFinish} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [TblW-1:0]     r_expected;
  logic [TblW-1:0]     r_table;
  logic [N_INPUTS-1:0] r_index;
  logic [CntW-1:0]     r_cnt;
  logic [N_INPUTS:0]   r_mism;
  logic                r_rv;
  logic                w_last;
  logic                w_miss;

  assign w_last = (r_index == {N_INPUTS{1'b1}});
  assign w_miss = (bus.dut_y != r_expected[r_index]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (bus.start) w_state_next = StDrive;
      StDrive: begin
        if (bus.abort)          w_state_next = StIdle;
        else if (r_cnt == '0)   w_state_next = StSample;
      end
      StSample: begin
        if (bus.abort)          w_state_next = StIdle;
        else if (w_last)        w_state_next = StFinish;
        else                    w_state_next = StDrive;
      end
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == StDrive) || (r_state == StSample);
    bus.done = (r_state == StFinish);
  end

  // The index doubles as the registered gate vector; it is parked at 0 whenever not sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected <= '0;
      r_table    <= '0;
      r_index    <= '0;
      r_cnt      <= '0;
      r_mism     <= '0;
      r_rv       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_expected <= bus.expected;
            r_table    <= '0;
            r_index    <= '0;
            r_cnt      <= CntReload;
            r_mism     <= '0;
            r_rv       <= 1'b0;
          end
        end
        StDrive: begin
          if (bus.abort) begin
            r_index <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StSample: begin
          if (bus.abort) begin
            r_index <= '0;
          end else begin
            r_table[r_index] <= bus.dut_y;
            if (w_miss) r_mism <= r_mism + (N_INPUTS + 1)'(1);
            if (w_last) begin
              r_rv <= 1'b1;
            end else begin
              r_index <= r_index + N_INPUTS'(1);
              r_cnt   <= CntReload;
            end
          end
        end
        StFinish: r_index <= '0;
        default:  r_index <= '0;
      endcase
    end
  end

  assign bus.dut_in         = r_index;
  assign bus.table_out      = r_table;
  assign bus.mismatch_count = r_mism;
  assign bus.result_valid   = r_rv;
  assign bus.pass           = r_rv && (r_mism == '0);
endmodule
